// File: rtl/mem_xfer_pkg.sv
// Shared types and helpers for the memory transfer engine.
// Holds the FSM state encoding, default sizes and burst length clamp.
package mem_xfer_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        XFER   = 3'd2,
        UNLOAD = 3'd3,
        DONE   = 3'd4
    } state_t;

    // A zero or oversized request means a full-depth burst.
    function automatic int unsigned eff_len(
        input int unsigned len,
        input int unsigned depth
    );
        return (len == 0 || len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read and flush.
// Ports: clk, rst, flush, push/wdata, pop/rdata, full, empty.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [2**AW];
    logic [AW:0]       wp;
    logic [AW:0]       rp;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit tells a wrapped (full) FIFO from an empty one.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wp[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/mem_xfer_engine.sv
// Burst load -> FIFO move (copy/reverse) -> stream unload, with XOR checks.
// Ports: start/len/reverse/abort control, in_* load, out_* unload, status.
module mem_xfer_engine
    import mem_xfer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int FIFO_AW = 2,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              reverse,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              chk_err,
    output logic [CNT_W-1:0]  xfer_cnt
);

    localparam int IW = $clog2(DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  l_len;
    logic              rev;
    logic [CNT_W-1:0]  ld_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [DATA_W-1:0] ld_chk;
    logic [DATA_W-1:0] ul_chk;
    logic [DATA_W-1:0] src [DEPTH];
    logic [DATA_W-1:0] dst [DEPTH];

    logic              aborting;
    logic              ld_hs;
    logic              ul_hs;
    logic              f_push;
    logic              f_pop;
    logic              f_full;
    logic              f_empty;
    logic [DATA_W-1:0] f_rdata;
    logic [IW-1:0]     dst_idx;

    // abort beats every handshake in the same cycle.
    assign aborting = abort && (state != IDLE);
    assign ld_hs    = (state == LOAD) && in_valid && in_ready && !abort;
    assign ul_hs    = (state == UNLOAD) && out_valid && out_ready && !abort;
    assign f_push   = (state == XFER) && !f_full && (wr_cnt < l_len) && !abort;
    assign f_pop    = (state == XFER) && !f_empty && !abort;

    assign dst_idx  = rev ? IW'(l_len - rd_cnt - CNT_W'(1))
                          : rd_cnt[IW-1:0];
    assign out_data = dst[out_cnt[IW-1:0]];
    assign busy     = (state != IDLE);
    assign xfer_cnt = rd_cnt;

    sync_fifo #(
        .DATA_W (DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (aborting),
        .push  (f_push),
        .wdata (src[wr_cnt[IW-1:0]]),
        .pop   (f_pop),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty)
    );

    always_ff @(posedge clk) begin
        if (ld_hs)
            src[ld_cnt[IW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (f_pop)
            dst[dst_idx] <= f_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            l_len     <= '0;
            rev       <= 1'b0;
            ld_cnt    <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            ld_chk    <= '0;
            ul_chk    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            chk_err   <= 1'b0;
        end else if (aborting) begin
            state     <= IDLE;
            ld_cnt    <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        l_len    <= CNT_W'(eff_len(32'(len), DEPTH));
                        rev      <= reverse;
                        ld_cnt   <= '0;
                        wr_cnt   <= '0;
                        rd_cnt   <= '0;
                        out_cnt  <= '0;
                        ld_chk   <= '0;
                        ul_chk   <= '0;
                        chk_err  <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (ld_hs) begin
                        ld_cnt <= ld_cnt + CNT_W'(1);
                        ld_chk <= ld_chk ^ in_data;
                        if (ld_cnt == l_len - CNT_W'(1)) begin
                            in_ready <= 1'b0;
                            state    <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (f_push)
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    if (f_pop) begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                        if (rd_cnt == l_len - CNT_W'(1)) begin
                            out_valid <= 1'b1;
                            out_last  <= (l_len == CNT_W'(1));
                            state     <= UNLOAD;
                        end
                    end
                end
                UNLOAD: begin
                    if (ul_hs) begin
                        ul_chk  <= ul_chk ^ out_data;
                        out_cnt <= out_cnt + CNT_W'(1);
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_last <= (out_cnt + CNT_W'(2) == l_len);
                        end
                    end
                end
                DONE: begin
                    chk_err <= (ld_chk != ul_chk);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_xfer_engine.md
Name: mem_xfer_engine

Overview:
- Parametrised single-clock successor to the feature-to-weight memory tester.
- Loads a programmable-length burst into a source buffer, moves it through an internal FIFO into a destination buffer (copy or reversed order), then streams it out with valid/ready and a last marker.
- Carries XOR checksums on the load and unload sides and flags any mismatch; serves as a self-checking datapath exerciser in front of compute memories.

Parameters:
- DATA_W, 8, word width in bits.
- DEPTH, 16, max burst length and buffer depth; power of 2.
- FIFO_AW, 2, internal FIFO address bits; FIFO depth is 2**FIFO_AW.
- CNT_W, $clog2(DEPTH)+1, width of the counters and of len.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin burst; sampled only in IDLE.
- len  in  CNT_W  burst length, latched on start; 0 or >DEPTH is treated as DEPTH.
- reverse  in  1  latched on start; 1 = destination stored in reversed order.
- abort  in  1  return to IDLE and flush the FIFO.
- in_data  in  DATA_W  load word.
- in_valid  in  1  load word valid.
- in_ready  out  1  engine accepts a load word.
- out_data  out  DATA_W  unload word.
- out_valid  out  1  unload word valid.
- out_ready  in  1  sink accepts the unload word.
- out_last  out  1  final word of the burst.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse on burst completion.
- chk_err  out  1  checksum mismatch; sticky until the next start.
- xfer_cnt  out  CNT_W  words written into the destination buffer so far.

Behaviour:
- Reset: state IDLE; all counters 0; FIFO empty; in_ready, out_valid, out_last, busy, done, chk_err, xfer_cnt all 0. Buffer contents are not reset.
- FSM states: IDLE, LOAD, XFER, UNLOAD, DONE.
- IDLE:
  - On start: latch L = effective len and rev = reverse; clear counters and both checksums; clear chk_err; go to LOAD.
- LOAD:
  - in_ready=1 while ld_cnt<L.
  - Each in_valid&in_ready cycle: src[ld_cnt]<=in_data; ld_cnt++; ld_chk^=in_data.
  - The handshake with ld_cnt==L-1 moves to XFER on the next cycle; in_ready is 0 from that cycle on.
- XFER:
  - Push src[wr_cnt] when !full && wr_cnt<L.
  - Pop when !empty; popped word goes to dst[rev ? L-1-rd_cnt : rd_cnt].
  - Push and pop may occur in the same cycle; the FIFO count is then unchanged.
  - FIFO read data is valid in the cycle of the pop (show-ahead).
  - xfer_cnt=rd_cnt. When rd_cnt reaches L, go to UNLOAD.
  - Minimum XFER duration is L+1 cycles.
- UNLOAD:
  - out_valid=1 and out_data=dst[out_cnt].
  - out_last=1 when out_cnt==L-1.
  - Data must hold stable while out_valid && !out_ready.
  - Each handshake: out_cnt++; ul_chk^=out_data.
  - The handshake on the last word moves to DONE.
- DONE:
  - done=1 for one cycle.
  - chk_err<=(ld_chk != final ul_chk).
  - Then go to IDLE.
- abort (any non-IDLE state):
  - Next cycle: IDLE, FIFO flushed, counters cleared, outputs deasserted, no done pulse.
  - abort has priority over every handshake in the same cycle.
- start outside IDLE is ignored. rst overrides everything.
- FIFO full: push stalls and wr_cnt holds. FIFO empty: pop stalls.
- Pointers are FIFO_AW+1 bits; the wrap bit distinguishes full from empty.
- Reverse mode with L=1 writes dst[0].
- Counters never exceed L; there is no wrap inside a burst.

Decomposition:
- Shared package mem_xfer_pkg:
  - state enum (IDLE=0, LOAD=1, XFER=2, UNLOAD=3, DONE=4).
  - effective-length function (0/>DEPTH -> DEPTH).
  - default DATA_W/DEPTH constants.
- One sub-module, sync_fifo:
  - Parameters DATA_W, AW.
  - Ports clk, rst, flush, push, wdata, pop, rdata, full, empty.
  - Show-ahead read.

Test Plan:
- Copy, len=16, reverse=0:
  - Load 0x00..0x0F with in_valid held high.
  - Expect out_data 0x00..0x0F in order, out_last on 0x0F, done pulse, chk_err=0, xfer_cnt=16.
- Reverse, len=5:
  - Load 0xA1,0xB2,0xC3,0xD4,0xE5.
  - Expect unload 0xE5,0xD4,0xC3,0xB2,0xA1 and out_last on 0xA1.
- len=0 and len=31:
  - Both behave as 16-word bursts.
  - in_ready drops after the 16th load word.
- Backpressure:
  - Toggle out_ready 1,0,0,1 with len=4.
  - out_data holds during stalls; exactly 4 handshakes occur; done fires exactly one cycle after the 4th.
- Abort mid-XFER (len=16, abort at xfer_cnt=6):
  - Next cycle busy=0, FIFO empty, no done pulse.
  - A following start with len=2 completes correctly.
- Start while busy and rst during UNLOAD:
  - start is ignored.
  - rst returns all outputs to their reset values on the next edge.
